// File: rtl/soc_system_pio_status_in.sv
// Avalon-MM input PIO: synchronizes a fabric status bus, captures per-bit edges into a
// write-1-to-clear register and raises a level interrupt for unmasked captured edges.
module soc_system_pio_status_in #(
  parameter int unsigned      WIDTH       = 19,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] AddrData    = 2'd0;
  localparam logic [1:0] AddrIrqMask = 2'd2;
  localparam logic [1:0] AddrEdgeCap = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] rise, fall, edge_det, clr;
  logic             wr_en;

  // Upper write-data bits have no storage when the bus is narrower than the word.
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect && !write_n;

  // Edge detection on the synchronized bus, mode fixed at elaboration.
  always_comb begin
    rise = sync2_q & ~prev_q;
    fall = ~sync2_q & prev_q;
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
  end

  // Next-state for synchronizer, mask, capture and the registered read mux.
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    mask_d = mask_q;
    if (wr_en && address == AddrIrqMask) begin
      mask_d = writedata[WIDTH-1:0];
    end

    clr = '0;
    if (wr_en && address == AddrEdgeCap) begin
      clr = writedata[WIDTH-1:0];
    end
    // A new edge overrides a same-cycle clear so no event is lost.
    cap_d = edge_det | (cap_q & ~clr);

    readdata_d = '0;
    case (address)
      AddrData:    readdata_d[WIDTH-1:0] = sync2_q;
      AddrIrqMask: readdata_d[WIDTH-1:0] = mask_q;
      AddrEdgeCap: readdata_d[WIDTH-1:0] = cap_q;
      default:     readdata_d = '0;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= RESET_VALUE;
      sync2_q    <= RESET_VALUE;
      prev_q     <= RESET_VALUE;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  // Built only from flops so the interrupt line cannot glitch.
  assign irq      = |(cap_q & mask_q);

endmodule

// File: doc/soc_system_pio_status_in.md
Name: soc_system_pio_status_in

Overview:
- Avalon-MM slave input PIO: the fabric-to-HPS companion of the HPS-driven output PIOs.
- Samples a WIDTH-bit asynchronous fabric status bus through a 2-FF synchronizer and exposes the synchronized value for HPS reads.
- Latches per-bit edges into a write-1-to-clear capture register.
- Raises a level interrupt for any captured edge that is unmasked.
- Sits on the lightweight HPS-to-FPGA bridge next to the output PIOs in soc_system.

Parameters:
- WIDTH, 19, width of in_port and of every internal register (1..32).
- EDGE_TYPE, 0, edge capture mode: 0 = rising, 1 = falling, 2 = any.
- RESET_VALUE, 0, reset value of the synchronizer and previous-sample registers (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- in_port  in  WIDTH  asynchronous fabric status inputs.
- readdata  out  32  Avalon read data, read latency 1.
- irq  out  1  level interrupt to HPS, active-high.

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk. Reset values:
  - sync1, sync2, prev = RESET_VALUE.
  - irq_mask = 0, edge_capture = 0.
  - readdata = 0, irq = 0.
- Synchronizer: sync1 <= in_port; sync2 <= sync1; prev <= sync2, every cycle.
- Edge detect (combinational, per bit):
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
  - edge = rise, fall or (rise|fall), selected by EDGE_TYPE.
- Register map (word address):
  - 0 data: RO, zero-extended sync2. Writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 irq_mask: RW, writedata[WIDTH-1:0].
  - 3 edge_capture: RO value; writing 1 to a bit clears that bit, writing 0 leaves it.
- Write condition: chipselect && !write_n. It takes effect at the next clk edge.
- readdata:
  - Registered every cycle: readdata <= zero-extended mux(address), independent of chipselect.
  - The master samples it one cycle after the address is presented.
  - Bits [31:WIDTH] are always 0.
- edge_capture update, per bit each cycle: cap <= edge | (cap & ~clear).
  - Set wins over a simultaneous W1C clear of the same bit. The bit stays 1 and no edge is lost.
- irq = |(edge_capture & irq_mask), driven directly from registers (glitch-free).
  - Masking a set bit deasserts irq without clearing the capture bit.
  - Unmasking a set bit reasserts irq.
- Latency: in_port changes and is stable before clk edge k.
  - sync2 updates at edge k+1.
  - edge_capture bit and irq set at edge k+2.
  - Data readdata shows the new value at edge k+2.
- Pulse rule: an in_port pulse shorter than one clk period may be missed. Any pulse held for 2 or more cycles is captured exactly once per qualifying edge.
- Multiple edges on a bit before a clear coalesce into one capture bit (no counting).
- Reset mid-operation:
  - All state returns to reset values immediately; irq drops asynchronously.
  - If in_port differs from RESET_VALUE after reset release, the resulting qualifying edge is captured normally.
- Reserved address: reads return 0 and writes have no effect.

Test Plan:
- Reset with in_port=19'h7FFFF and RESET_VALUE=0, then release: readdata@addr0 = 0x0007FFFF by the 3rd cycle; rising capture bits all 1; irq=0 because the mask is 0.
- EDGE_TYPE=0, mask=0x1, in_port bit0 0->1 before edge k: capture[0]=1 and irq=1 after edge k+2; the 1->0 transition sets nothing new.
- Write 0x1 to addr3: capture[0] clears and irq falls the cycle after the write. Write 0x0 to addr3: capture unchanged.
- Simultaneous W1C of bit3 and a new rising edge on bit3 in the same cycle: capture[3] stays 1 and irq stays asserted.
- Mask toggle: capture=0x4; write mask=0x4 -> irq=1; write mask=0 -> irq=0 while addr3 still reads 0x4; readback of addr2 returns the last written mask.
- EDGE_TYPE=2, toggle bit18 high then low: capture[18] set after each transition; addr1 reads 0; writes to addr0/addr1 change nothing; readdata[31:19] = 0 throughout.
